// File: rtl/core_types_pkg.sv
// rtl/core_types_pkg.sv - shared payload types for the dispatch core
//
// Purpose: payload structs that travel between core pipeline stages. Blocks
// such as handshake_fork take these as a type parameter and define no types
// of their own.
// Ports: none (package).
package core_types_pkg;

  // Dispatch packet handed from the decoder to the execution-side consumers.
  typedef struct packed {
    logic [2:0] opcode;
    logic [4:0] tag;
  } dispatch_pkt_t;

endpackage : core_types_pkg

// File: rtl/handshake_fork.sv
// rtl/handshake_fork.sv - one-entry valid/ready fork to N_OUT consumers
//
// Purpose: captures one upstream payload and offers it to N_OUT downstream
// consumers. Each consumer may accept on its own cycle. The entry retires once
// every consumer has taken it. A new entry can be captured on the same edge the
// old one retires, which gives one entry per cycle when all consumers are ready.
//
// Ports:
//   clk        - single clock, all state on posedge
//   reset      - synchronous active-high reset
//   flush      - synchronous flush, discards the held entry
//   valid_in   - upstream offers data_in
//   ready_in   - block can capture data_in this cycle
//   data_in    - upstream payload (type T)
//   valid_out  - per-consumer offer of the held entry
//   ready_out  - per-consumer acceptance
//   data_out   - held payload, shared by all consumers (registered only)
module handshake_fork #(
  parameter type T     = logic,
  parameter int  N_OUT = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             valid_in,
  output logic             ready_in,
  input  T                 data_in,
  output logic [N_OUT-1:0] valid_out,
  input  logic [N_OUT-1:0] ready_out,
  output T                 data_out
);

  logic             full_q,    full_d;
  logic [N_OUT-1:0] done_q,    done_d;
  T                 payload_q, payload_d;

  logic [N_OUT-1:0] accept;
  logic             complete;
  logic             capture;

  always_comb begin
    // Offers are masked during reset too, because a synchronous reset has not
    // yet cleared full_q in the cycle it is first asserted.
    valid_out = (full_q && !flush && !reset) ? ~done_q : '0;
    accept    = valid_out & ready_out;
    // Retire when every consumer has either taken the entry earlier or is
    // taking it right now.
    complete  = full_q && (&(done_q | accept));
    ready_in  = (!full_q || complete) && !flush && !reset;
    capture   = valid_in && ready_in;
  end

  always_comb begin
    full_d    = full_q;
    done_d    = done_q;
    payload_d = payload_q;
    if (flush) begin
      // Flush wins over every handshake; payload is left as-is since no
      // consumer can see it once full is clear.
      full_d = 1'b0;
      done_d = '0;
    end else if (capture) begin
      // Covers both an empty block and retire-plus-refill on the same edge.
      full_d    = 1'b1;
      done_d    = '0;
      payload_d = data_in;
    end else if (complete) begin
      full_d = 1'b0;
      done_d = '0;
    end else begin
      done_d = done_q | accept;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      full_q    <= 1'b0;
      done_q    <= '0;
      payload_q <= '0;
    end else begin
      full_q    <= full_d;
      done_q    <= done_d;
      payload_q <= payload_d;
    end
  end

  assign data_out = payload_q;

endmodule : handshake_fork

// File: tb/tb_handshake_fork.sv
// tb/tb_handshake_fork.sv - self-checking bench for handshake_fork
module tb_handshake_fork;
  import core_types_pkg::*;

  localparam int N = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          flush;
  logic          valid_in;
  logic          ready_in;
  logic [7:0]    din_bits;
  dispatch_pkt_t data_in;
  logic [N-1:0]  valid_out;
  logic [N-1:0]  ready_out;
  dispatch_pkt_t data_out;
  logic [7:0]    dout_bits;

  int checks   = 0;
  int failures = 0;

  assign data_in   = din_bits;
  assign dout_bits = data_out;

  always #5 clk = ~clk;

  handshake_fork #(.T(dispatch_pkt_t), .N_OUT(N)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .valid_in  (valid_in),
    .ready_in  (ready_in),
    .data_in   (data_in),
    .valid_out (valid_out),
    .ready_out (ready_out),
    .data_out  (data_out)
  );

  // Transaction-level reference: one held entry plus the set of consumers
  // that have already been served from it.
  bit       m_live = 1'b0;
  bit       m_full = 1'b0;
  bit [7:0] m_pay  = '0;
  bit       m_served [N];

  initial for (int i = 0; i < N; i++) m_served[i] = 1'b0;

  function automatic bit m_offer(int i);
    return m_full && !m_served[i] && !flush && !reset;
  endfunction

  function automatic bit m_retire();
    if (!m_full) return 1'b0;
    for (int i = 0; i < N; i++)
      if (!(m_served[i] || (m_offer(i) && ready_out[i]))) return 1'b0;
    return 1'b1;
  endfunction

  function automatic bit m_can_take();
    return (!m_full || m_retire()) && !flush && !reset;
  endfunction

  always @(posedge clk) begin
    bit take, retire;
    take   = valid_in && m_can_take();
    retire = m_retire();
    if (reset) begin
      m_live <= 1'b1;
      m_full <= 1'b0;
      m_pay  <= '0;
      for (int i = 0; i < N; i++) m_served[i] <= 1'b0;
    end else if (flush) begin
      m_full <= 1'b0;
      for (int i = 0; i < N; i++) m_served[i] <= 1'b0;
    end else if (take) begin
      m_full <= 1'b1;
      m_pay  <= din_bits;
      for (int i = 0; i < N; i++) m_served[i] <= 1'b0;
    end else if (retire) begin
      m_full <= 1'b0;
      for (int i = 0; i < N; i++) m_served[i] <= 1'b0;
    end else begin
      for (int i = 0; i < N; i++)
        if (m_offer(i) && ready_out[i]) m_served[i] <= 1'b1;
    end
  end

  // Per-cycle comparison against the reference, away from the active edge.
  always @(negedge clk) begin
    if (m_live) begin
      logic [N-1:0] exp_vo;
      for (int i = 0; i < N; i++) exp_vo[i] = m_offer(i);
      checks++;
      if (ready_in !== m_can_take()) begin
        failures++;
        $display("FAIL model_ready_in t=%0t got=%0b exp=%0b", $time, ready_in, m_can_take());
      end
      checks++;
      if (valid_out !== exp_vo) begin
        failures++;
        $display("FAIL model_valid_out t=%0t got=%b exp=%b", $time, valid_out, exp_vo);
      end
      checks++;
      if (dout_bits !== m_pay) begin
        failures++;
        $display("FAIL model_data_out t=%0t got=%h exp=%h", $time, dout_bits, m_pay);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s t=%0t got=%h exp=%h", name, $time, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; valid_in = 1'b0; din_bits = '0; ready_out = '0;
    tick(); tick();
    #2;
    chk("rst_ready_in", ready_in, 0);
    chk("rst_valid_out", valid_out, 0);
    chk("rst_data_out", dout_bits, 0);

    // Single transfer
    tick();
    reset = 1'b0; ready_out = 2'b11;
    #2 chk("post_rst_ready_in", ready_in, 1);
    valid_in = 1'b1; din_bits = 8'h5A;
    #2 chk("single_ready_at_capture", ready_in, 1);
    tick();
    valid_in = 1'b0;
    #2;
    chk("single_valid_out", valid_out, 2'b11);
    chk("single_data_out", dout_bits, 8'h5A);
    tick();
    #2 chk("single_cleared", valid_out, 2'b00);

    // Staggered accept
    tick();
    ready_out = 2'b00; valid_in = 1'b1; din_bits = 8'hA1;
    tick();
    valid_in = 1'b0; ready_out = 2'b01;
    #2; chk("stag_vo_0", valid_out, 2'b11); chk("stag_ri_0", ready_in, 0);
    tick();
    #2; chk("stag_vo_1", valid_out, 2'b10); chk("stag_ri_1", ready_in, 0);
    tick();
    #2; chk("stag_vo_2", valid_out, 2'b10); chk("stag_ri_2", ready_in, 0);
    tick();
    ready_out = 2'b10;
    #2; chk("stag_vo_3", valid_out, 2'b10); chk("stag_ri_3", ready_in, 1);
    tick();
    #2 chk("stag_vo_4", valid_out, 2'b00);

    // Back-to-back streaming
    ready_out = 2'b11;
    for (int k = 0; k < 8; k++) begin
      valid_in = 1'b1; din_bits = 8'(k);
      #2 chk("stream_ready_in", ready_in, 1);
      if (k > 0) begin
        chk("stream_data", dout_bits, 32'(k - 1));
        chk("stream_vo", valid_out, 2'b11);
      end
      tick();
    end
    valid_in = 1'b0;
    #2; chk("stream_last_data", dout_bits, 8'h07); chk("stream_last_vo", valid_out, 2'b11);
    tick();

    // Flush mid-transaction
    valid_in = 1'b1; din_bits = 8'h33; ready_out = 2'b00;
    tick();
    valid_in = 1'b0; ready_out = 2'b01;
    #2 chk("flush_pre_vo", valid_out, 2'b11);
    tick();
    ready_out = 2'b00; flush = 1'b1; valid_in = 1'b1; din_bits = 8'h44;
    #2; chk("flush_ready_in", ready_in, 0); chk("flush_vo", valid_out, 2'b00);
    tick();
    flush = 1'b0; valid_in = 1'b0;
    #2; chk("flush_after_vo", valid_out, 2'b00); chk("flush_after_ri", ready_in, 1);
    valid_in = 1'b1; din_bits = 8'h55; ready_out = 2'b11;
    tick();
    valid_in = 1'b0;
    #2; chk("flush_next_data", dout_bits, 8'h55); chk("flush_next_vo", valid_out, 2'b11);
    tick();

    // Reset mid-transaction
    valid_in = 1'b1; din_bits = 8'h66; ready_out = 2'b00;
    tick();
    valid_in = 1'b0; ready_out = 2'b01;
    tick();
    ready_out = 2'b00; reset = 1'b1;
    #2; chk("rstmid_vo", valid_out, 2'b00); chk("rstmid_ri", ready_in, 0);
    tick();
    reset = 1'b0;
    #2;
    chk("rstmid_after_ri", ready_in, 1);
    chk("rstmid_after_vo", valid_out, 2'b00);
    chk("rstmid_after_data", dout_bits, 8'h00);

    // Ready without valid
    ready_out = 2'b11;
    for (int k = 0; k < 3; k++) begin
      #2; chk("idle_vo", valid_out, 2'b00); chk("idle_ri", ready_in, 1);
      tick();
    end
    ready_out = 2'b00; valid_in = 1'b1; din_bits = 8'h77;
    tick();
    valid_in = 1'b0;
    #2; chk("idle_then_vo", valid_out, 2'b11); chk("idle_then_data", dout_bits, 8'h77);
    ready_out = 2'b11;
    tick();
    #2 chk("idle_then_clear", valid_out, 2'b00);

    // Randomized traffic, checked by the reference every cycle
    for (int c = 0; c < 3000; c++) begin
      tick();
      valid_in  = ($urandom_range(0, 3) != 0);
      din_bits  = 8'($urandom);
      ready_out = 2'($urandom_range(0, 3));
      flush     = ($urandom_range(0, 31) == 0);
      reset     = ($urandom_range(0, 127) == 0);
    end
    tick();
    reset = 1'b0; flush = 1'b0; valid_in = 1'b0; ready_out = 2'b11;
    tick(); tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_handshake_fork

// File: doc/handshake_fork.md
HANDSHAKE_FORK -- requirements
Module: handshake_fork

Interface
REQ-001 Parameter: T, default logic, payload type carried upstream to downstream.
REQ-002 Parameter: N_OUT, default 2, number of downstream consumers (legal range 2..8).
REQ-003 Port: clk  input  1  single clock; all state updates on posedge clk.
REQ-004 Port: reset  input  1  synchronous, active-high reset.
REQ-005 Port: flush  input  1  synchronous pipeline flush; discards the held entry.
REQ-006 Port: valid_in  input  1  upstream offers data_in.
REQ-007 Port: ready_in  output  1  block can capture data_in this cycle.
REQ-008 Port: data_in  input  $bits(T)  upstream payload.
REQ-009 Port: valid_out  output  N_OUT  per-consumer offer of the held entry.
REQ-010 Port: ready_out  input  N_OUT  per-consumer acceptance.
REQ-011 Port: data_out  output  $bits(T)  held payload, shared by all consumers.

Function
REQ-012 The block SHALL hold one entry (full flag, payload register) and a done[N_OUT] mask of consumers that have already accepted it.
REQ-013 The upstream handshake SHALL occur on a cycle with valid_in && ready_in; payload is captured at that edge.
REQ-014 data_out SHALL be driven only from the payload register, with no combinational path from data_in; latency from capture to valid_out is exactly 1 cycle.
REQ-015 valid_out[i] SHALL be full && !done[i] && !flush.
REQ-016 Consumer i SHALL count as accepted on a cycle with valid_out[i] && ready_out[i]; done[i] is set at that edge.
REQ-017 complete SHALL be asserted when full and, for every i, done[i] or (valid_out[i] && ready_out[i]) holds; consumers may accept in any order and on different cycles.
REQ-018 ready_in SHALL be (!full || complete) && !flush && !reset, so that throughput is 1 entry/cycle when all consumers are ready.
REQ-019 On complete without a new capture, the block SHALL clear full and done at that edge.
REQ-020 On complete with a simultaneous capture, the block SHALL keep full = 1, load the new payload, and clear done to 0.
REQ-021 A consumer that has accepted SHALL NOT see valid_out again for the same entry, even if it keeps ready_out high.
REQ-022 flush SHALL take priority over all handshakes: at the edge, full and done are cleared, no capture occurs, and no consumer acceptance is recorded.
REQ-023 The payload register SHALL hold its value while full and no capture occurs, and SHALL be stable while any valid_out bit is high.

Reset
REQ-024 On reset, the block SHALL set full = 0, done = 0 and payload = 0.
REQ-025 While reset is asserted, the block SHALL drive valid_out = 0 and ready_in = 0.
REQ-026 In the first cycle after reset deasserts, ready_in SHALL be 1.
REQ-027 Reset asserted mid-transaction SHALL discard a partially accepted entry, with no valid_out on the following cycle.

Structure
REQ-028 The payload struct types passed as T (for example the dispatch packet) SHALL live in the core's shared types package; the block SHALL define no package of its own.
REQ-029 The block SHALL be a single flat module with no sub-modules; the done mask and full flag are local registers.

Verification
REQ-030 Scenario, single transfer: N_OUT=2, ready_out=2'b11, one valid_in with data 0x5A -> ready_in=1 at capture; valid_out=2'b11 and data_out=0x5A next cycle; full cleared the cycle after.
REQ-031 Scenario, staggered accept: ready_out=2'b01 for 3 cycles, then 2'b10 -> valid_out steps 2'b11, 2'b10, 2'b10, 2'b10, then 0; ready_in=0 until the cycle consumer 1 accepts.
REQ-032 Scenario, back-to-back streaming: 8 payloads 0..7 with valid_in held high and ready_out=all-ones -> one payload completes per cycle, in order, with no bubbles.
REQ-033 Scenario, flush mid-transaction: consumer 0 has accepted 0x33 and flush pulses for 1 cycle with valid_in=1 -> no capture; valid_out=0 next cycle; the following valid_in is captured normally.
REQ-034 Scenario, reset mid-transaction: entry held with done=2'b01, reset pulses -> valid_out=0 and ready_in=0 during reset; ready_in=1 and valid_out=0 after reset.
REQ-035 Scenario, ready without valid: ready_out=all-ones while the block is empty -> no done bits set and no spurious complete.
